// File: rtl/wb_bus_pkg.sv
// Shared types and helpers for the Wishbone shared-bus matrix.
package wb_bus_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned SLOT_W = 32;

    // Extract 32-bit slot idx from a flattened (zero-extended) base/mask vector.
    function automatic logic [31:0] slot32(input logic [255:0] vec, input int unsigned idx);
        return vec[8'(SLOT_W * idx) +: 32];
    endfunction

    // First requester strictly after last (wrapping over n masters); last if none.
    function automatic logic [IDX_W-1:0] rr_next(input logic [7:0] req,
                                                 input logic [IDX_W-1:0] last,
                                                 input int unsigned n);
        logic [IDX_W-1:0] pick;
        logic [IDX_W-1:0] idx;
        logic             found;
        pick  = last;
        found = 1'b0;
        for (int unsigned k = 1; k <= 8; k++) begin
            idx = IDX_W'((32'(last) + k) % n);
            if (!found && k <= n && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Round-robin bus arbiter: grants one requester and holds it until its cyc drops.
module wb_rr_arbiter
    import wb_bus_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     cyc,
    output logic [IDX_W-1:0] grant,
    output logic             valid
);

    arb_state_t       state;
    logic [IDX_W-1:0] last_grant;
    logic             cyc_g;

    always_comb begin
        cyc_g = 1'b0;
        for (int unsigned m = 0; m < N; m++) begin
            if (grant == IDX_W'(m)) begin
                cyc_g = cyc[m];
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state      <= IDLE;
            grant      <= '0;
            valid      <= 1'b0;
            last_grant <= IDX_W'(N - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant <= rr_next(8'(req), last_grant, N);
                        valid <= 1'b1;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!cyc_g) begin
                        valid      <= 1'b0;
                        last_grant <= grant;
                        state      <= IDLE;
                    end
                end
                default: begin
                    valid <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/wb_bus_matrix.sv
// Shared-bus Wishbone matrix: round-robin master arbitration, address decode,
// per-master read-data hold, unmapped-address and stall-timeout error generation.
module wb_bus_matrix
    import wb_bus_pkg::*;
#(
    parameter int unsigned             WB_DWIDTH = 32,
    parameter int unsigned             WB_SWIDTH = 4,
    parameter int unsigned             N_MASTERS = 4,
    parameter int unsigned             N_SLAVES  = 4,
    parameter logic [N_SLAVES*32-1:0]  SLV_BASE  = '0,
    parameter logic [N_SLAVES*32-1:0]  SLV_MASK  = '0,
    parameter int unsigned             TIMEOUT   = 255
) (
    input  logic                           i_wb_clk,
    input  logic                           i_arst_n,
    input  logic [N_MASTERS*32-1:0]        i_m_wb_adr,
    input  logic [N_MASTERS*WB_SWIDTH-1:0] i_m_wb_sel,
    input  logic [N_MASTERS-1:0]           i_m_wb_we,
    input  logic [N_MASTERS*WB_DWIDTH-1:0] i_m_wb_dat,
    input  logic [N_MASTERS-1:0]           i_m_wb_cyc,
    input  logic [N_MASTERS-1:0]           i_m_wb_stb,
    output logic [N_MASTERS*WB_DWIDTH-1:0] o_m_wb_dat,
    output logic [N_MASTERS-1:0]           o_m_wb_ack,
    output logic [N_MASTERS-1:0]           o_m_wb_err,
    output logic [N_SLAVES*32-1:0]         o_s_wb_adr,
    output logic [N_SLAVES*WB_SWIDTH-1:0]  o_s_wb_sel,
    output logic [N_SLAVES-1:0]            o_s_wb_we,
    output logic [N_SLAVES*WB_DWIDTH-1:0]  o_s_wb_dat,
    output logic [N_SLAVES-1:0]            o_s_wb_cyc,
    output logic [N_SLAVES-1:0]            o_s_wb_stb,
    input  logic [N_SLAVES*WB_DWIDTH-1:0]  i_s_wb_dat,
    input  logic [N_SLAVES-1:0]            i_s_wb_ack
);

    localparam int unsigned DW = WB_DWIDTH;
    localparam int unsigned SW = WB_SWIDTH;
    localparam int unsigned NM = N_MASTERS;
    localparam int unsigned NS = N_SLAVES;

    logic [31:0]      m_adr [NM];
    logic [SW-1:0]    m_sel [NM];
    logic [DW-1:0]    m_dat [NM];
    logic [DW-1:0]    s_dat [NS];
    logic [NM-1:0]    req;
    logic [IDX_W-1:0] grant;
    logic             grant_vld;

    logic [31:0]      g_adr;
    logic [SW-1:0]    g_sel;
    logic [DW-1:0]    g_dat;
    logic             g_we, g_cyc, g_stb;
    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic             r_ack;
    logic [DW-1:0]    r_dat;
    logic             live, active, ack_c, tmo_c, err_c;
    logic             unm_err;
    logic [CNT_W-1:0] stall_cnt;

    assign req = i_m_wb_cyc & i_m_wb_stb;

    for (genvar m = 0; m < NM; m++) begin : g_unpack_m
        assign m_adr[m] = i_m_wb_adr[32*m +: 32];
        assign m_sel[m] = i_m_wb_sel[SW*m +: SW];
        assign m_dat[m] = i_m_wb_dat[DW*m +: DW];
    end

    for (genvar s = 0; s < NS; s++) begin : g_unpack_s
        assign s_dat[s] = i_s_wb_dat[DW*s +: DW];
    end

    wb_rr_arbiter #(.N(NM)) u_arb (
        .clk    (i_wb_clk),
        .arst_n (i_arst_n),
        .req    (req),
        .cyc    (i_m_wb_cyc),
        .grant  (grant),
        .valid  (grant_vld)
    );

    // Granted master's request signals
    always_comb begin
        g_adr = '0;
        g_sel = '0;
        g_dat = '0;
        g_we  = 1'b0;
        g_cyc = 1'b0;
        g_stb = 1'b0;
        for (int unsigned m = 0; m < NM; m++) begin
            if (grant == IDX_W'(m)) begin
                g_adr = m_adr[m];
                g_sel = m_sel[m];
                g_dat = m_dat[m];
                g_we  = i_m_wb_we[m];
                g_cyc = i_m_wb_cyc[m];
                g_stb = i_m_wb_stb[m];
            end
        end
    end

    // Address decode; the lowest matching slot wins
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned s = 0; s < NS; s++) begin
            if (!hit && ((g_adr & slot32(256'(SLV_MASK), s)) == slot32(256'(SLV_BASE), s))) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(s);
            end
        end
    end

    always_comb begin
        r_ack = 1'b0;
        r_dat = '0;
        for (int unsigned s = 0; s < NS; s++) begin
            if (hit_idx == IDX_W'(s)) begin
                r_ack = i_s_wb_ack[s];
                r_dat = s_dat[s];
            end
        end
    end

    assign live   = grant_vld & g_cyc;
    assign active = live & g_stb;
    assign ack_c  = active & hit & r_ack;
    assign tmo_c  = active & hit & (stall_cnt == CNT_W'(TIMEOUT - 1));
    // ack always takes precedence over either error source
    assign err_c  = live & ~ack_c & (unm_err | tmo_c);

    for (genvar s = 0; s < NS; s++) begin : g_slave
        logic sel_s;
        assign sel_s                  = live & hit & (hit_idx == IDX_W'(s));
        assign o_s_wb_cyc[s]          = sel_s;
        assign o_s_wb_stb[s]          = sel_s & g_stb & ~tmo_c;
        assign o_s_wb_we[s]           = sel_s & g_we;
        assign o_s_wb_adr[32*s +: 32] = g_adr;
        assign o_s_wb_sel[SW*s +: SW] = g_sel;
        assign o_s_wb_dat[DW*s +: DW] = g_dat;
    end

    for (genvar m = 0; m < NM; m++) begin : g_master
        logic          is_g;
        logic [DW-1:0] held;
        assign is_g                   = (grant == IDX_W'(m));
        assign o_m_wb_ack[m]          = ack_c & is_g;
        assign o_m_wb_err[m]          = err_c & is_g;
        assign o_m_wb_dat[DW*m +: DW] = (ack_c && is_g) ? r_dat : held;

        // Last data acked to this master
        always_ff @(posedge i_wb_clk or negedge i_arst_n) begin
            if (!i_arst_n) begin
                held <= '0;
            end else if (ack_c && is_g) begin
                held <= r_dat;
            end
        end
    end

    // Unmapped-strobe error (one cycle later) and stall timeout counter
    always_ff @(posedge i_wb_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            unm_err   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            unm_err <= active & ~hit & ~unm_err;
            if (!active || !hit || ack_c || tmo_c) begin
                stall_cnt <= '0;
            end else begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_wb_bus_matrix.sv
// Directed plus randomized bench for wb_bus_matrix against a transaction-level model.
`timescale 1ns/1ps
module tb_wb_bus_matrix;

    localparam int unsigned NM = 4;
    localparam int unsigned NS = 2;
    localparam logic [63:0] BASE = {32'h8000_0000, 32'h0000_0000};
    localparam logic [63:0] MASK = {32'hF000_0000, 32'hF000_0000};

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic [31:0]   madr [NM];
    logic [3:0]    msel [NM];
    logic [31:0]   mdat [NM];
    logic [NM-1:0] mwe, mcyc, mstb, pend;
    logic [127:0]  m_adr_f, m_dat_f;
    logic [15:0]   m_sel_f;
    logic [31:0]   rdata [NS];
    logic [NS-1:0] auto_ack, force_ack, s_ack;
    logic [63:0]   s_dat_f;
    logic [31:0]   held [NM];

    logic [127:0]  o_m_wb_dat;
    logic [NM-1:0] o_m_wb_ack, o_m_wb_err;
    logic [63:0]   o_s_wb_adr, o_s_wb_dat;
    logic [7:0]    o_s_wb_sel;
    logic [NS-1:0] o_s_wb_we, o_s_wb_cyc, o_s_wb_stb;

    int vectors = 0;
    int miscompares = 0;
    int last;

    always #5 clk = ~clk;

    for (genvar m = 0; m < NM; m++) begin : g_m
        assign m_adr_f[32*m +: 32] = madr[m];
        assign m_dat_f[32*m +: 32] = mdat[m];
        assign m_sel_f[4*m +: 4]   = msel[m];
    end
    for (genvar s = 0; s < NS; s++) begin : g_s
        assign s_ack[s]            = (auto_ack[s] & o_s_wb_stb[s]) | force_ack[s];
        assign s_dat_f[32*s +: 32] = rdata[s];
    end

    wb_bus_matrix #(
        .WB_DWIDTH(32), .WB_SWIDTH(4), .N_MASTERS(NM), .N_SLAVES(NS),
        .SLV_BASE(BASE), .SLV_MASK(MASK), .TIMEOUT(8)
    ) dut (
        .i_wb_clk(clk), .i_arst_n(arst_n),
        .i_m_wb_adr(m_adr_f), .i_m_wb_sel(m_sel_f), .i_m_wb_we(mwe),
        .i_m_wb_dat(m_dat_f), .i_m_wb_cyc(mcyc), .i_m_wb_stb(mstb),
        .o_m_wb_dat(o_m_wb_dat), .o_m_wb_ack(o_m_wb_ack), .o_m_wb_err(o_m_wb_err),
        .o_s_wb_adr(o_s_wb_adr), .o_s_wb_sel(o_s_wb_sel), .o_s_wb_we(o_s_wb_we),
        .o_s_wb_dat(o_s_wb_dat), .o_s_wb_cyc(o_s_wb_cyc), .o_s_wb_stb(o_s_wb_stb),
        .i_s_wb_dat(s_dat_f), .i_s_wb_ack(s_ack)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] onehot(input int i);
        logic [127:0] r;
        r = '0;
        if (i >= 0) r[i] = 1'b1;
        return r;
    endfunction

    // Slave 0 owns 0x0xxx_xxxx, slave 1 owns 0x8xxx_xxxx, everything else unmapped
    function automatic int decode(input logic [31:0] a);
        if (a[31:28] == 4'h0) return 0;
        if (a[31:28] == 4'h8) return 1;
        return -1;
    endfunction

    function automatic logic [31:0] mdat_of(input int m);
        logic [127:0] t;
        t = o_m_wb_dat;
        return t[32*m +: 32];
    endfunction

    function automatic int pick(input logic [NM-1:0] p, input int lst);
        int idx;
        for (int k = 1; k <= NM; k++) begin
            idx = (lst + k) % NM;
            if (p[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [31:0] rand_addr();
        int n;
        n = $urandom_range(0, 4);
        if (n < 2) return {4'h0, 28'($urandom)};
        if (n < 4) return {4'h8, 28'($urandom)};
        n = $urandom_range(1, 14);
        if (n >= 8) n++;
        return {4'(n), 28'($urandom)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int m, input logic [31:0] a);
        madr[m] = a; mdat[m] = $urandom; msel[m] = 4'($urandom); mwe[m] = 1'($urandom);
        mcyc[m] = 1'b1; mstb[m] = 1'b1; pend[m] = 1'b1;
    endtask

    task automatic drop(input int m);
        mcyc[m] = 1'b0; mstb[m] = 1'b0; pend[m] = 1'b0;
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        for (int m = 0; m < NM; m++) held[m] = '0;
        last = NM - 1;
    endtask

    // One single-beat transfer by master w, starting from IDLE and ending back in IDLE
    task automatic serve(input int w, input logic [31:0] rd);
        int s;
        s = decode(madr[w]);
        if (s >= 0) rdata[s] = rd;
        tick();
        if (s >= 0) begin
            chk("ack", o_m_wb_ack, onehot(w));
            chk("err", o_m_wb_err, '0);
            chk("s_cyc", o_s_wb_cyc, onehot(s));
            chk("s_stb", o_s_wb_stb, onehot(s));
            chk("s_we", o_s_wb_we, mwe[w] ? onehot(s) : '0);
            chk("s_adr", o_s_wb_adr, {madr[w], madr[w]});
            chk("s_dat", o_s_wb_dat, {mdat[w], mdat[w]});
            chk("s_sel", o_s_wb_sel, {msel[w], msel[w]});
            chk("m_dat", mdat_of(w), rd);
            held[w] = rd;
            tick();
            drop(w);
            #1;
            chk("ack_off", o_m_wb_ack, '0);
            chk("s_cyc_off", o_s_wb_cyc, '0);
            for (int m = 0; m < NM; m++) chk("held", mdat_of(m), held[m]);
        end else begin
            chk("unm_ack", o_m_wb_ack, '0);
            chk("unm_err0", o_m_wb_err, '0);
            chk("unm_cyc", o_s_wb_cyc, '0);
            chk("unm_stb", o_s_wb_stb, '0);
            tick();
            chk("unm_err1", o_m_wb_err, onehot(w));
            chk("unm_ack1", o_m_wb_ack, '0);
            tick();
            chk("unm_err2", o_m_wb_err, '0);
            drop(w);
        end
        tick();
        last = w;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        int order [5];
        int w;
        order = '{0, 1, 2, 3, 0};
        for (int m = 0; m < NM; m++) begin
            madr[m] = '0; mdat[m] = '0; msel[m] = '0;
        end
        mwe = '0; mcyc = '0; mstb = '0; pend = '0;
        auto_ack = '1; force_ack = '0;
        rdata[0] = '0; rdata[1] = '0;
        do_reset();

        // Reset state with requests already pending
        set_req(0, 32'h0000_0100);
        set_req(2, 32'h0000_0200);
        tick(); tick();
        chk("rst_s_cyc", o_s_wb_cyc, '0);
        chk("rst_s_stb", o_s_wb_stb, '0);
        chk("rst_s_we", o_s_wb_we, '0);
        chk("rst_ack", o_m_wb_ack, '0);
        chk("rst_err", o_m_wb_err, '0);
        chk("rst_dat", o_m_wb_dat, '0);
        arst_n = 1'b1;

        // Masters 0 and 2 together: 0 first, then 2
        serve(0, $urandom);
        serve(2, $urandom);

        // All four continuously requesting from reset: 0,1,2,3,0
        do_reset();
        tick();
        for (int m = 0; m < NM; m++) set_req(m, {1'b0, 31'($urandom)} & 32'h8FFF_FFFF);
        arst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            serve(order[i], $urandom);
            set_req(order[i], {4'h8, 28'($urandom)});
        end
        for (int m = 0; m < NM; m++) drop(m);

        // Read from slave 1, data held after ack
        set_req(0, 32'h8000_0010);
        mwe[0] = 1'b0;
        serve(0, 32'hDEADBEEF);
        tick();
        chk("held_deadbeef", mdat_of(0), 32'hDEADBEEF);

        // Unmapped access
        set_req(1, 32'h4000_0000);
        serve(1, '0);

        // Stall timeout, then ack coinciding with timeout
        auto_ack[0] = 1'b0;
        set_req(0, 32'h0000_0040);
        tick();
        for (int c = 1; c <= 8; c++) begin
            chk("tmo_err", o_m_wb_err, (c == 8) ? onehot(0) : '0);
            chk("tmo_stb", o_s_wb_stb, (c == 8) ? '0 : onehot(0));
            tick();
        end
        for (int c = 1; c <= 8; c++) begin
            if (c == 8) begin
                rdata[0] = 32'h1234_5678;
                force_ack[0] = 1'b1;
                #1;
            end
            chk("tmo_ack", o_m_wb_ack, (c == 8) ? onehot(0) : '0);
            chk("tmo_err_ack", o_m_wb_err, '0);
            tick();
        end
        force_ack[0] = 1'b0;
        drop(0);
        #1;
        chk("tmo_held", mdat_of(0), 32'h1234_5678);
        held[0] = 32'h1234_5678;
        tick();
        last = 0;
        auto_ack[0] = 1'b1;

        // Abort: granted master drops cyc mid-transfer
        auto_ack[1] = 1'b0;
        set_req(2, 32'h8000_0100);
        tick();
        chk("abort_cyc_on", o_s_wb_cyc, onehot(1));
        drop(2);
        #1;
        chk("abort_cyc_off", o_s_wb_cyc, '0);
        chk("abort_stb_off", o_s_wb_stb, '0);
        force_ack[1] = 1'b1;
        #1;
        chk("abort_ack", o_m_wb_ack, '0);
        chk("abort_err", o_m_wb_err, '0);
        force_ack[1] = 1'b0;
        auto_ack[1] = 1'b1;
        tick();
        last = 2;

        // Randomized traffic checked against the round-robin model
        for (int i = 0; i < 60; i++) begin
            for (int m = 0; m < NM; m++)
                if (!pend[m] && $urandom_range(0, 2) == 0) set_req(m, rand_addr());
            if (pend == '0) set_req($urandom_range(0, NM - 1), rand_addr());
            w = pick(pend, last);
            serve(w, $urandom);
        end
        for (int m = 0; m < NM; m++) drop(m);

        // Reset mid-burst, then master 0 wins the first request
        set_req(1, 32'h0000_0300);
        set_req(3, 32'h8000_0300);
        w = pick(pend, last);
        rdata[0] = $urandom; rdata[1] = $urandom;
        tick();
        chk("burst_ack", o_m_wb_ack, onehot(w));
        do_reset();
        #1;
        chk("mid_rst_s_cyc", o_s_wb_cyc, '0);
        chk("mid_rst_s_stb", o_s_wb_stb, '0);
        chk("mid_rst_ack", o_m_wb_ack, '0);
        chk("mid_rst_err", o_m_wb_err, '0);
        chk("mid_rst_dat", o_m_wb_dat, '0);
        tick();
        set_req(0, 32'h8000_0400);
        arst_n = 1'b1;
        serve(0, $urandom);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
